// File: rtl/axis_packet_framer.sv
// AXI-Stream packet framer: buffers raw words, drops null-strobe beats and cuts
// the stream into packets of cfg_pkt_len beats with a generated tlast.
module axis_packet_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    axis_aclk,
  input  logic                    axis_areset,
  input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic [15:0]             pkt_count,
  output logic                    short_pkt_err
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_WIDTH + STRB_W + 1;

  typedef enum logic [1:0] {
    PKT_IDLE = 2'd0,
    PKT_BODY = 2'd1,
    PKT_LAST = 2'd2
  } pkt_state_t;

  logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           fifo_count;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] head_data;
  logic [STRB_W-1:0]     head_strb;
  logic                  head_last;

  pkt_state_t            state;
  pkt_state_t            state_next;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  start;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [LEN_WIDTH-1:0]  next_cnt;
  logic                  at_len;
  logic                  end_pkt;
  logic                  set_short;
  logic                  out_hs;
  logic                  pkt_done;

  // Reset gates tready directly so no beat is taken while the block is held.
  assign s01_axis_tready = ~axis_areset & (fifo_count < (AW+1)'(FIFO_DEPTH));
  assign wr_en  = s01_axis_tvalid & s01_axis_tready & (s01_axis_tstrb != '0);
  assign rd_en  = (fifo_count != '0) & (~m01_axis_tvalid | m01_axis_tready);
  assign out_hs = m01_axis_tvalid & m01_axis_tready;
  assign {head_data, head_strb, head_last} = mem[rd_ptr];

  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem[wr_ptr] <= {s01_axis_tdata, s01_axis_tstrb, s01_axis_tlast};
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) state <= PKT_IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PKT_IDLE: if (rd_en) state_next = end_pkt ? PKT_LAST : PKT_BODY;
      PKT_BODY: if (rd_en && end_pkt) state_next = PKT_LAST;
      PKT_LAST: begin
        // A load on the closing handshake opens the next packet directly.
        if (rd_en)       state_next = end_pkt ? PKT_LAST : PKT_BODY;
        else if (out_hs) state_next = PKT_IDLE;
      end
      default: state_next = PKT_IDLE;
    endcase
  end

  always_comb begin
    start     = rd_en & (state != PKT_BODY);
    eff_len   = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
    cur_len   = start ? eff_len : len_q;
    next_cnt  = start ? LEN_WIDTH'(1) : beat_cnt + 1'b1;
    at_len    = (next_cnt == cur_len);
    end_pkt   = at_len | head_last;
    set_short = rd_en & head_last & ~at_len;
    pkt_done  = out_hs & m01_axis_tlast;
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      len_q           <= '0;
      beat_cnt        <= '0;
      m01_axis_tdata  <= '0;
      m01_axis_tstrb  <= '0;
      m01_axis_tvalid <= 1'b0;
      m01_axis_tlast  <= 1'b0;
      pkt_count       <= '0;
      short_pkt_err   <= 1'b0;
    end else begin
      if (start) len_q <= eff_len;
      if (rd_en) begin
        beat_cnt        <= next_cnt;
        m01_axis_tdata  <= head_data;
        m01_axis_tstrb  <= head_strb;
        m01_axis_tvalid <= 1'b1;
        m01_axis_tlast  <= end_pkt;
      end else if (out_hs) begin
        m01_axis_tvalid <= 1'b0;
      end
      if (pkt_done)  pkt_count     <= pkt_count + 1'b1;
      if (set_short) short_pkt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_packet_framer.sv
// Directed and randomized checks of axis_packet_framer against a beat-level
// packetization model held in a queue.
module tb_axis_packet_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [15:0] pkt_count;
  logic        short_err;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    m_pos = 0;
  int    m_len = 1;
  int    m_pkts = 0;
  bit    m_short = 1'b0;
  bit    rand_rdy = 1'b0;

  axis_packet_framer #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .LEN_WIDTH(8)) dut (
    .axis_aclk       (clk),
    .axis_areset     (rst),
    .cfg_pkt_len     (cfg),
    .s01_axis_tdata  (s_tdata),
    .s01_axis_tstrb  (s_tstrb),
    .s01_axis_tvalid (s_tvalid),
    .s01_axis_tlast  (s_tlast),
    .s01_axis_tready (s_tready),
    .m01_axis_tdata  (m_tdata),
    .m01_axis_tstrb  (m_tstrb),
    .m01_axis_tvalid (m_tvalid),
    .m01_axis_tlast  (m_tlast),
    .m01_axis_tready (m_tready),
    .pkt_count       (pkt_count),
    .short_pkt_err   (short_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Packet rules applied to the sequence of kept beats.
  task automatic model_accept(input logic [31:0] d, input logic [3:0] st, input logic l);
    beat_t b;
    if (st == 4'd0) return;
    if (m_pos == 0) m_len = (cfg == 8'd0) ? 1 : int'(cfg);
    m_pos++;
    b.d = d;
    b.s = st;
    b.l = (m_pos == m_len) || l;
    if (l && m_pos != m_len) m_short = 1'b1;
    exp_q.push_back(b);
    if (b.l) begin
      m_pos = 0;
      m_pkts++;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] st, input logic l);
    int n = 0;
    s_tdata  = d;
    s_tstrb  = st;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (s_tready) model_accept(d, st, l);
    else chk("send_stuck", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", m_tdata, e.d);
        chk("out_strb", 32'(m_tstrb), 32'(e.s));
        chk("out_last", 32'(m_tlast), 32'(e.l));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    cfg      = 8'd4;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_short", 32'(short_err), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;

    // Two full packets of 4.
    cfg = 8'd4;
    for (int i = 1; i <= 8; i++) send(32'(i), 4'hF, 1'b0);
    drain();
    chk("p1_pkt_count", 32'(pkt_count), 32'd2);
    chk("p1_short", 32'(short_err), 32'd0);

    // Early upstream tlast.
    cfg = 8'd5;
    send(32'hA, 4'hF, 1'b0);
    send(32'hB, 4'hF, 1'b0);
    send(32'hC, 4'hF, 1'b1);
    drain();
    chk("p2_pkt_count", 32'(pkt_count), 32'd3);
    chk("p2_short", 32'(short_err), 32'd1);

    // Null-strobe beat is dropped.
    cfg = 8'd2;
    send(32'h1, 4'hF, 1'b0);
    send(32'h2, 4'h0, 1'b1);
    send(32'h3, 4'h3, 1'b0);
    drain();
    chk("p3_pkt_count", 32'(pkt_count), 32'd4);

    // Backpressure: 16 FIFO entries plus the output register.
    cfg = 8'd4;
    m_tready = 1'b0;
    for (int i = 0; i < 17; i++) send(32'h100 + 32'(i), 4'hF, 1'b0);
    s_tdata  = 32'h111;
    s_tstrb  = 4'hF;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_s_tready", 32'(s_tready), 32'd0);
      chk("stall_tvalid", 32'(m_tvalid), 32'd1);
      chk("stall_tdata", m_tdata, 32'h100);
      chk("stall_tlast", 32'(m_tlast), 32'd0);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 17; i < 20; i++) send(32'h100 + 32'(i), 4'hF, 1'b0);
    drain();
    chk("p4_pkt_count", 32'(pkt_count), 32'd9);

    // Length 0 behaves as 1.
    cfg = 8'd0;
    for (int i = 0; i < 3; i++) send(32'h200 + 32'(i), 4'hF, 1'b0);
    drain();
    chk("p5_pkt_count", 32'(pkt_count), 32'd12);

    // Random data, strobes, early ends and output stalls.
    cfg = 8'($urandom_range(1, 6));
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send($urandom,
           ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
           ($urandom_range(0, 7) == 0));
    end
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    drain();
    chk("rnd_pkt_count", 32'(pkt_count), 32'(m_pkts));
    chk("rnd_short", 32'(short_err), 32'(m_short));

    // Reset with a partial packet buffered.
    cfg = 8'd8;
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h300 + 32'(i), 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("mid_rst_short", 32'(short_err), 32'd0);
    chk("mid_rst_s_tready", 32'(s_tready), 32'd0);
    exp_q.delete();
    m_pos = 0;
    m_pkts = 0;
    m_short = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_tready = 1'b1;
    cfg = 8'd2;
    for (int i = 0; i < 3; i++) send(32'h400 + 32'(i), 4'hF, 1'b0);
    drain();
    chk("post_rst_pkt_count", 32'(pkt_count), 32'(m_pkts));
    chk("post_rst_short", 32'(short_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_packet_framer.md
Name: axis_packet_framer

Overview:
- Upstream stage for the AXI-Stream memory controller.
- Accepts a raw word stream on an AXI-Stream slave, buffers it in a small FIFO and drops null-strobe beats.
- Cuts the stream into packets of a programmable length with a generated tlast, so every beat it emits carries non-zero tstrb and a defined packet boundary.
- Drives the controller's s01_axis slave port through an m01_axis master port.

Parameters:
DATA_WIDTH, 32, stream data width in bits (multiple of 8)
FIFO_DEPTH, 16, buffer entries; power of two, >= 2
LEN_WIDTH, 8, width of cfg_pkt_len

Ports:
axis_aclk  input  1  single clock for the whole block
axis_areset  input  1  asynchronous, active-high reset
cfg_pkt_len  input  LEN_WIDTH  beats per packet; 0 is treated as 1
s01_axis_tdata  input  DATA_WIDTH  input word
s01_axis_tstrb  input  DATA_WIDTH/8  input byte strobes
s01_axis_tvalid  input  1  input beat valid
s01_axis_tlast  input  1  upstream early packet end
s01_axis_tready  output  1  block can accept a beat
m01_axis_tdata  output  DATA_WIDTH  output word
m01_axis_tstrb  output  DATA_WIDTH/8  output strobes
m01_axis_tvalid  output  1  output beat valid
m01_axis_tlast  output  1  last beat of packet
m01_axis_tready  input  1  downstream accepts beat
pkt_count  output  16  packets emitted, wraps at 65535 -> 0
short_pkt_err  output  1  sticky: a packet was ended early by s01_axis_tlast

Behaviour:
- Interface: one clock, axis_aclk. Asynchronous active-high reset, axis_areset.

Reset:
- While axis_areset is high, all of the following are 0: FIFO count and pointers, beat counter, FSM state (PKT_IDLE), all m01 outputs, pkt_count, short_pkt_err.
- s01_axis_tready is 0 while axis_areset is high.
- s01_axis_tready rises in the first cycle after release.
- Reset mid-packet discards all buffered and in-flight data; no tlast is emitted for the partial packet.

Input side:
- s01_axis_tready = (fifo_count < FIFO_DEPTH), combinational from registered count.
- A beat is accepted on a rising edge with tvalid & tready.
- An accepted beat with tstrb == 0 is dropped: not stored, and its tlast is ignored.
- An accepted beat with non-zero tstrb writes {tdata, tstrb, tlast} into the FIFO.
- When the FIFO is full, tready is 0 and there is no pass-through even if the output pops that cycle.

Output register:
- Loads from the FIFO when the FIFO is non-empty and (m01_axis_tvalid == 0 or m01_axis_tready == 1).
- Load and pop occur on the same edge.
- Latency: a beat accepted at edge N into an empty FIFO with an idle output appears with m01_axis_tvalid = 1 after edge N+1.
- Once m01_axis_tvalid is high, tdata, tstrb, tvalid and tlast hold stable until the handshake.
- Full throughput: 1 beat per cycle when neither side stalls.
- Simultaneous FIFO write and pop: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Packet FSM (advances on each output-register load):
- PKT_IDLE: no packet open.
  - On load: latch len = max(cfg_pkt_len, 1) and set beat_cnt = 1.
  - If len == 1 or the entry's tlast is set: tlast = 1, go to PKT_LAST.
  - Otherwise go to PKT_BODY.
- PKT_BODY:
  - On load: beat_cnt + 1.
  - If beat_cnt + 1 == len or the entry's tlast is set: tlast = 1, go to PKT_LAST.
  - Otherwise tlast = 0.
- PKT_LAST:
  - On the handshake of the tlast beat, pkt_count increments.
  - If a new load happens on that same edge, it is handled as a PKT_IDLE load.
  - Otherwise go to PKT_IDLE.
- cfg_pkt_len changes take effect only at the next packet start.

Short packets:
- An entry tlast ending a packet before beat_cnt reaches len sets short_pkt_err.
- short_pkt_err clears only on reset.
- An entry tlast on exactly beat len is normal.
- Length expiry with no entry tlast still ends the packet. The following words start a new packet.

Test Plan:
- Reset, cfg_pkt_len = 4, send 8 words 0x1..0x8 with tstrb = 0xF and no tlast; tready always 1 -> 8 output beats in order; tlast on 0x4 and 0x8; pkt_count = 2; short_pkt_err = 0.
- Send 0xA, 0xB and 0xC with tlast on 0xC, cfg_pkt_len = 5 -> 3 beats, tlast on 0xC, short_pkt_err = 1, pkt_count + 1.
- Send 0x1, then 0x2 with tstrb = 0, then 0x3; cfg_pkt_len = 2 -> output 0x1, 0x3 with tlast on 0x3; 0x2 is never emitted.
- Hold m01_axis_tready = 0 and stream 20 words -> s01_axis_tready drops after 16 FIFO writes plus 1 word held in the output register. Data stays stable. Releasing tready drains all 17 in order with no loss or duplication.
- cfg_pkt_len = 0, send 3 words -> every beat has tlast = 1 and pkt_count = 3.
- Assert axis_areset mid-packet with 5 words buffered -> m01_axis_tvalid = 0 and pkt_count = 0 immediately. After release the next packet starts at beat 1.
